// File: rtl/encr_fifo_ctrl_pkg.sv
// Shared types and helpers for the encryption payload FIFO controller.
// State encodings, default widths and the saturating increment.
package encr_fifo_ctrl_pkg;

  localparam int ENC_NB_ADRESS   = 3;
  localparam int ENC_N_ADRESS    = 8;
  localparam int ENC_NB_COUNTER  = 16;
  localparam int ENC_NB_LOCK     = 3;
  localparam int ENC_LOCK_FRAMES = 4;
  localparam int ENC_NB_STATE    = 3;

  typedef enum logic [ENC_NB_STATE-1:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_FILL     = 3'd2,
    ST_RUN      = 3'd3,
    ST_RESYNC   = 3'd4
  } state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] lim
  );
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/encr_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over an increment in the same cycle.
module encr_sat_counter
  import encr_fifo_ctrl_pkg::*;
#(
  parameter int NB = 16
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [NB-1:0] o_count
);

  localparam logic [31:0] MAX = 32'({NB{1'b1}});

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= NB'(sat_inc(32'(o_count), MAX));
    end
  end

endmodule

// File: rtl/encr_payload_fifo_ctrl.sv
// Encryption payload FIFO sequencer: frame alignment, pre-fill,
// read-stall passthrough, overflow/underflow resync and lock tracking.
module encr_payload_fifo_ctrl
  import encr_fifo_ctrl_pkg::*;
#(
  parameter int NB_ADRESS   = ENC_NB_ADRESS,
  parameter int N_ADRESS    = ENC_N_ADRESS,
  parameter int NB_COUNTER  = ENC_NB_COUNTER,
  parameter int NB_LOCK     = ENC_NB_LOCK,
  parameter int LOCK_FRAMES = ENC_LOCK_FRAMES
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_rf_enable,
  input  logic [NB_ADRESS-1:0]  i_rf_prefill,
  input  logic [NB_ADRESS-1:0]  i_rf_hi_mark,
  input  logic                  i_rf_clear_counters,
  input  logic                  i_frame_start,
  input  logic                  i_valid,
  input  logic                  i_gap_req,
  input  logic [NB_ADRESS-1:0]  i_fifo_level,
  output logic                  o_fifo_enable,
  output logic                  o_restart_wr_ptr,
  output logic                  o_stop_read,
  output logic [2:0]            o_state,
  output logic                  o_locked,
  output logic [NB_COUNTER-1:0] o_ovf_resync_count,
  output logic [NB_COUNTER-1:0] o_udf_resync_count
);

  localparam logic [NB_ADRESS:0] PF_MAX  = (NB_ADRESS+1)'(N_ADRESS - 2);
  localparam logic [NB_LOCK-1:0] LOCK_MX = NB_LOCK'(LOCK_FRAMES);

  state_t               st;
  logic [NB_ADRESS-1:0] fill_cnt;
  logic [NB_ADRESS:0]   fill_sum;
  logic [NB_ADRESS:0]   prefill_eff;
  logic [NB_LOCK-1:0]   clean_cnt;
  logic [NB_LOCK-1:0]   clean_nxt;
  logic                 run_act;
  logic                 ovf_evt;
  logic                 udf_evt;

  // Out-of-range pre-fill is clamped so FILL always terminates.
  always_comb begin
    prefill_eff = {1'b0, i_rf_prefill};
    if (i_rf_prefill == '0) begin
      prefill_eff = (NB_ADRESS+1)'(1);
    end else if ({1'b0, i_rf_prefill} > PF_MAX) begin
      prefill_eff = PF_MAX;
    end
  end

  assign fill_sum  = {1'b0, fill_cnt} + (NB_ADRESS+1)'(i_valid);
  assign clean_nxt = NB_LOCK'(sat_inc(32'(clean_cnt),
                                      32'(LOCK_FRAMES)));

  assign run_act = i_rf_enable && (st == ST_RUN);
  assign ovf_evt = run_act && (i_fifo_level >= i_rf_hi_mark);
  assign udf_evt = run_act && !ovf_evt &&
                   (i_fifo_level == '0) && !o_stop_read;

  assign o_state = 3'(st);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || !i_rf_enable) begin
      st               <= ST_IDLE;
      o_fifo_enable    <= 1'b0;
      o_restart_wr_ptr <= 1'b0;
      o_stop_read      <= 1'b1;
      o_locked         <= 1'b0;
      fill_cnt         <= '0;
      clean_cnt        <= '0;
    end else begin
      o_restart_wr_ptr <= 1'b0;
      case (st)
        ST_IDLE: begin
          o_fifo_enable <= 1'b1;
          o_stop_read   <= 1'b1;
          st            <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF: begin
          o_fifo_enable <= 1'b1;
          o_stop_read   <= 1'b1;
          if (i_frame_start) begin
            o_restart_wr_ptr <= 1'b1;
            fill_cnt         <= '0;
            st               <= ST_FILL;
          end
        end
        ST_FILL: begin
          o_stop_read <= 1'b1;
          fill_cnt    <= fill_sum[NB_ADRESS-1:0];
          if (fill_sum >= prefill_eff) begin
            o_stop_read <= 1'b0;
            st          <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ovf_evt || udf_evt) begin
            o_fifo_enable <= 1'b0;
            o_stop_read   <= 1'b1;
            o_locked      <= 1'b0;
            clean_cnt     <= '0;
            st            <= ST_RESYNC;
          end else begin
            o_stop_read <= i_gap_req;
            if (i_frame_start) begin
              clean_cnt <= clean_nxt;
              o_locked  <= (clean_nxt == LOCK_MX);
            end
          end
        end
        ST_RESYNC: begin
          o_fifo_enable <= 1'b1;
          o_stop_read   <= 1'b1;
          st            <= ST_WAIT_SOF;
        end
        default: begin
          o_fifo_enable <= 1'b0;
          o_stop_read   <= 1'b1;
          o_locked      <= 1'b0;
          clean_cnt     <= '0;
          st            <= ST_IDLE;
        end
      endcase
    end
  end

  encr_sat_counter #(.NB(NB_COUNTER)) u_ovf_cnt (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (i_rf_clear_counters),
    .i_inc     (ovf_evt),
    .o_count   (o_ovf_resync_count)
  );

  encr_sat_counter #(.NB(NB_COUNTER)) u_udf_cnt (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (i_rf_clear_counters),
    .i_inc     (udf_evt),
    .o_count   (o_udf_resync_count)
  );

endmodule

// File: tb/tb_encr_payload_fifo_ctrl.sv
// Scoreboard bench for encr_payload_fifo_ctrl.
// Directed stimulus queues expected output snapshots; a monitor checks them.
module tb_encr_payload_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  prefill;
  logic [2:0]  hi_mark;
  logic        clr;
  logic        fs;
  logic        valid;
  logic        gap;
  logic [2:0]  level;
  logic        fifo_en;
  logic        restart;
  logic        stop_rd;
  logic [2:0]  state;
  logic        locked;
  logic [15:0] ovf_cnt;
  logic [15:0] udf_cnt;

  encr_payload_fifo_ctrl dut (
    .i_clock             (clk),
    .i_reset_n           (rst_n),
    .i_rf_enable         (en),
    .i_rf_prefill        (prefill),
    .i_rf_hi_mark        (hi_mark),
    .i_rf_clear_counters (clr),
    .i_frame_start       (fs),
    .i_valid             (valid),
    .i_gap_req           (gap),
    .i_fifo_level        (level),
    .o_fifo_enable       (fifo_en),
    .o_restart_wr_ptr    (restart),
    .o_stop_read         (stop_rd),
    .o_state             (state),
    .o_locked            (locked),
    .o_ovf_resync_count  (ovf_cnt),
    .o_udf_resync_count  (udf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    logic [38:0] val;
    logic [38:0] msk;
  } exp_t;

  exp_t q[$];
  int   applied = 0;
  int   miss = 0;

  logic [38:0] act;
  assign act = {state, fifo_en, restart, stop_rd, locked, ovf_cnt, udf_cnt};

  function automatic logic [38:0] pk(
    input logic [2:0] s, input logic e, input logic r,
    input logic p, input logic l,
    input logic [15:0] o, input logic [15:0] u
  );
    return {s, e, r, p, l, o, u};
  endfunction

  localparam logic [38:0] M_ST  = {3'b111, 36'd0};
  localparam logic [38:0] M_EN  = 39'd1 << 35;
  localparam logic [38:0] M_RS  = 39'd1 << 34;
  localparam logic [38:0] M_SP  = 39'd1 << 33;
  localparam logic [38:0] M_ALL = {39{1'b1}};
  localparam logic [38:0] M_CTL = M_ST | M_EN | M_RS | M_SP;

  task automatic chk(input string nm, input logic [38:0] v,
                     input logic [38:0] m);
    exp_t e;
    e.cyc = cyc + 1;
    e.nm  = nm;
    e.val = v;
    e.msk = m;
    q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      applied++;
      if (e.cyc != cyc) begin
        miss++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d",
                 e.nm, e.cyc, cyc);
      end else if (((act ^ e.val) & e.msk) !== '0) begin
        miss++;
        $display("FAIL %s @%0d: got st=%0d en=%b rs=%b sr=%b lk=%b ovf=%0d udf=%0d, want st=%0d en=%b rs=%b sr=%b lk=%b ovf=%0d udf=%0d mask=%h",
                 e.nm, cyc, act[38:36], act[35], act[34], act[33],
                 act[32], act[31:16], act[15:0], e.val[38:36], e.val[35],
                 e.val[34], e.val[33], e.val[32], e.val[31:16],
                 e.val[15:0], e.msk);
      end
    end
  end

  // From WAIT_SOF: frame start, one idle cycle, then four valids.
  task automatic go_run(input string tag);
    fs = 1'b1;
    chk({tag, "_sof"}, pk(3'd2, 1, 1, 1, 0, 0, 0), M_CTL);
    step;
    fs = 1'b0;
    chk({tag, "_rs_pulse"}, pk(3'd2, 1, 0, 1, 0, 0, 0), M_CTL);
    step;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      chk($sformatf("%s_fill%0d", tag, i),
          (i == 3) ? pk(3'd3, 1, 0, 0, 0, 0, 0)
                   : pk(3'd2, 1, 0, 1, 0, 0, 0), M_CTL);
      step;
    end
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; prefill = 3'd4; hi_mark = 3'd6;
    clr = 1'b0; fs = 1'b0; valid = 1'b0; gap = 1'b0; level = 3'd3;

    step;
    chk("reset", pk(3'd0, 0, 0, 1, 0, 0, 0), M_ALL);
    step;
    rst_n = 1'b1; en = 1'b1;
    chk("enable", pk(3'd1, 1, 0, 1, 0, 0, 0), M_ALL);
    step;
    chk("wait_sof", pk(3'd1, 1, 0, 1, 0, 0, 0), M_ALL);
    step;
    go_run("nom");

    for (int k = 1; k <= 4; k++) begin
      fs = 1'b1;
      chk($sformatf("lock_sof%0d", k),
          pk(3'd3, 1, 0, 0, (k == 4), 0, 0), M_ALL);
      step;
      fs = 1'b0;
      chk($sformatf("lock_hold%0d", k),
          pk(3'd3, 1, 0, 0, (k == 4), 0, 0), M_ALL);
      step;
    end

    for (int i = 0; i < 3; i++) begin
      gap = 1'b1;
      chk($sformatf("gap%0d", i), pk(3'd3, 1, 0, 1, 1, 0, 0), M_ALL);
      step;
    end
    gap = 1'b0;
    chk("gap_end", pk(3'd3, 1, 0, 0, 1, 0, 0), M_ALL);
    step;
    level = 3'd5;
    chk("below_hi", pk(3'd3, 1, 0, 0, 1, 0, 0), M_ALL);
    step;

    level = 3'd6;
    chk("ovf_resync", pk(3'd4, 0, 0, 1, 0, 1, 0), M_ALL);
    step;
    level = 3'd3;
    chk("ovf_rewait", pk(3'd1, 1, 0, 1, 0, 1, 0), M_ALL);
    step;
    go_run("ovf");

    level = 3'd0;
    chk("udf_resync", pk(3'd4, 0, 0, 1, 0, 1, 1), M_ALL);
    step;
    level = 3'd3; fs = 1'b1;
    chk("udf_sof_drop", pk(3'd1, 1, 0, 1, 0, 1, 1), M_ALL);
    step;
    fs = 1'b0;
    chk("udf_wait", pk(3'd1, 1, 0, 1, 0, 1, 1), M_ALL);
    step;
    go_run("udf");

    level = 3'd6;
    chk("ovf2", pk(3'd4, 0, 0, 1, 0, 2, 1), M_ALL);
    step;
    level = 3'd3;
    chk("ovf2_wait", pk(3'd1, 1, 0, 1, 0, 2, 1), M_ALL);
    step;
    fs = 1'b1;
    chk("dis_sof", pk(3'd2, 1, 1, 1, 0, 2, 1), M_ALL);
    step;
    fs = 1'b0; valid = 1'b1;
    chk("dis_fill", pk(3'd2, 1, 0, 1, 0, 2, 1), M_ALL);
    step;
    en = 1'b0;
    chk("disable", pk(3'd0, 0, 0, 1, 0, 2, 1), M_ALL);
    step;
    valid = 1'b0;
    chk("dis_hold", pk(3'd0, 0, 0, 1, 0, 2, 1), M_ALL);
    step;

    rst_n = 1'b0; en = 1'b1;
    chk("rst_clear", pk(3'd0, 0, 0, 1, 0, 0, 0), M_ALL);
    step;
    rst_n = 1'b1;
    chk("rst_enable", pk(3'd1, 1, 0, 1, 0, 0, 0), M_ALL);
    step;
    go_run("rst");

    level = 3'd6;
    chk("ovf3", pk(3'd4, 0, 0, 1, 0, 1, 0), M_ALL);
    step;
    level = 3'd3;
    chk("ovf3_wait", pk(3'd1, 1, 0, 1, 0, 1, 0), M_ALL);
    step;
    go_run("clr");
    level = 3'd6; clr = 1'b1;
    chk("clr_inc", pk(3'd4, 0, 0, 1, 0, 0, 0), M_ALL);
    step;
    clr = 1'b0; level = 3'd3;
    chk("clr_after", pk(3'd1, 1, 0, 1, 0, 0, 0), M_ALL);
    step;

    for (int i = 0; i < 10 && q.size() > 0; i++) step;
    if (q.size() > 0) begin
      miss++;
      applied++;
      $display("FAIL drain: %0d checks pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end

endmodule

// File: doc/encr_payload_fifo_ctrl.md
Name: encr_payload_fifo_ctrl

Overview:
- Sequencing controller for the encryption payload FIFO.
- Enables the FIFO and aligns its write pointer to frame starts. Holds reads until a programmed pre-fill is reached, then passes downstream stall requests through.
- Detects overflow/underflow from the FIFO level and runs a resync: disable one cycle, wait for the next frame, refill.
- Sits between the framer/stall logic and the FIFO, and reports lock status and resync counters to the register file.

Parameters:
- NB_ADRESS, 3, width of FIFO level and pre-fill fields.
- N_ADRESS, 8, FIFO depth; must equal 2**NB_ADRESS.
- NB_COUNTER, 16, width of the resync counters.
- NB_LOCK, 3, width of the clean-frame counter.
- LOCK_FRAMES, 4, consecutive clean frames required to assert lock; must be below 2**NB_LOCK.

Ports:
- i_clock, in, 1, clock.
- i_reset_n, in, 1, synchronous active-low reset.
- i_rf_enable, in, 1, controller enable.
- i_rf_prefill, in, NB_ADRESS, words to write before the first read; valid range 1..N_ADRESS-2.
- i_rf_hi_mark, in, NB_ADRESS, overflow threshold on FIFO level.
- i_rf_clear_counters, in, 1, single-cycle clear of both resync counters.
- i_frame_start, in, 1, frame-start pulse; precedes the frame's first i_valid by at least 1 cycle.
- i_valid, in, 1, payload word written to the FIFO this cycle.
- i_gap_req, in, 1, downstream request to stall reads this cycle.
- i_fifo_level, in, NB_ADRESS, FIFO fill level.
- o_fifo_enable, out, 1, FIFO static enable; low clears the FIFO pointers.
- o_restart_wr_ptr, out, 1, write-pointer restart pulse.
- o_stop_read, out, 1, FIFO read inhibit.
- o_state, out, 3, current FSM state encoding.
- o_locked, out, 1, FIFO aligned and stable.
- o_ovf_resync_count, out, NB_COUNTER, resyncs caused by overflow.
- o_udf_resync_count, out, NB_COUNTER, resyncs caused by underflow.

Behaviour:
- All outputs are registered. Reset values: state IDLE, o_fifo_enable=0, o_restart_wr_ptr=0, o_stop_read=1, o_locked=0, both counters 0.
- IDLE (0): o_fifo_enable=0, o_stop_read=1. When i_rf_enable=1, go to WAIT_SOF and set o_fifo_enable=1.
- WAIT_SOF (1): o_stop_read=1. On i_frame_start, pulse o_restart_wr_ptr for exactly one cycle (the next cycle), clear fill_cnt, go to FILL.
- FILL (2): o_stop_read=1. fill_cnt increments on i_valid. When fill_cnt+i_valid reaches i_rf_prefill, go to RUN; o_stop_read drops in the first RUN cycle.
- RUN (3): o_stop_read <= i_gap_req, giving 1 cycle of latency from i_gap_req to o_stop_read. Event checks, in priority order:
  - overflow: i_fifo_level >= i_rf_hi_mark → RESYNC, increment ovf counter.
  - underflow: i_fifo_level==0 while o_stop_read==0 → RESYNC, increment udf counter.
  - clean frame: i_frame_start with neither event → increment clean_cnt, saturating at LOCK_FRAMES.
  - o_locked=1 when clean_cnt==LOCK_FRAMES.
- RESYNC (4): first cycle o_fifo_enable=0, o_stop_read=1, o_locked=0, clean_cnt cleared. Next cycle o_fifo_enable=1 and go to WAIT_SOF.
- An i_frame_start coincident with an event or inside RESYNC is dropped; alignment uses the next frame.
- i_rf_enable=0 in any state → IDLE next cycle with reset-equivalent outputs. Counters are held, not cleared.
- Counters saturate at all-ones.
- i_rf_clear_counters has priority over an increment in the same cycle; the result is 0.
- Reset asserted mid-frame → IDLE next cycle regardless of state.
- States 5..7 are illegal; they recover to IDLE.
- Both events in one cycle cannot occur (level 0 < hi_mark). If i_rf_hi_mark==0, overflow wins every cycle; this is a documented misconfiguration.

Decomposition:
- Shared package encr_fifo_ctrl_pkg holds:
  - state encodings ST_IDLE..ST_RESYNC;
  - constant widths;
  - a saturating-increment function used by both resync counters and clean_cnt.
- One sub-module is natural: encr_sat_counter, parameterised by width, with clear/inc/saturate, instantiated twice for the resync counters.

Test Plan:
- Nominal start: reset, enable, i_rf_prefill=4, frame_start at t0, valid every cycle from t0+2.
  - o_restart_wr_ptr pulses only at t0+1.
  - o_stop_read falls at t0+6.
  - State sequence 1→2→3.
- Lock: 4 clean frame_starts in RUN with LOCK_FRAMES=4 → o_locked=1 on the cycle after the 4th; counters stay 0.
- Overflow: i_rf_hi_mark=6, drive level 6 in RUN.
  - Next cycle: state 4, o_fifo_enable=0, o_locked=0, ovf count=1.
  - Following cycle: o_fifo_enable=1, state 1.
- Underflow: level 0 with o_stop_read=0 → udf count=1, RESYNC. A frame_start during RESYNC is ignored; realignment occurs on the following frame_start.
- Gap passthrough: i_gap_req high for cycles 10-12 in RUN → o_stop_read high for cycles 11-13; no resync.
- Disable/reset: i_rf_enable=0 mid-FILL → IDLE, o_stop_read=1, counters kept. Then i_reset_n=0 → counters 0 next cycle. Clear-plus-increment in the same cycle → count 0.
